// File: rtl/imm_encoder.sv
// Two-stage immediate packer: S1 captures the input beat, S2 holds the encoded
// instruction with its range flag, word address and a saturating error tally.
module imm_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_type,
    input  logic [31:0] imm_val,
    input  logic [31:0] base_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        range_err,
    output logic [31:0] out_addr,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_type_q;
    logic [31:0] s1_imm_q;
    logic [31:0] s1_base_q;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_instr_q;
    logic        s2_err_q;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        in_accept;
    logic        s1_adv;
    logic        out_xfer;
    logic [31:0] enc_instr;
    logic        enc_err;

    // S2 may take a new beat whenever it is empty or draining this cycle.
    assign out_xfer  = s2_valid_q & out_ready;
    assign s1_adv    = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready  = ~s1_valid_q | s1_adv;
    assign in_accept = in_valid & in_ready;

    assign s1_valid_d = in_accept | (s1_valid_q & ~s1_adv);
    assign s2_valid_d = s1_adv | (s2_valid_q & ~out_xfer);

    always_comb begin
        addr_d      = addr_q;
        err_count_d = err_count_q;
        if (out_xfer) begin
            addr_d = addr_q + 32'd4;
            if (s2_err_q && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // Fields not owned by the immediate pass through from base_instr; excess
    // immediate bits are dropped and only reported through the error flag.
    always_comb begin
        enc_instr = s1_base_q;
        enc_err   = 1'b0;
        case (s1_type_q)
            IMM_I: begin
                enc_instr[31:20] = s1_imm_q[11:0];
                enc_err = ~((&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]));
            end
            IMM_S: begin
                enc_instr[31:25] = s1_imm_q[11:5];
                enc_instr[11:7]  = s1_imm_q[4:0];
                enc_err = ~((&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]));
            end
            IMM_B: begin
                enc_instr[31]    = s1_imm_q[12];
                enc_instr[7]     = s1_imm_q[11];
                enc_instr[30:25] = s1_imm_q[10:5];
                enc_instr[11:8]  = s1_imm_q[4:1];
                enc_err = ~((&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12])) | s1_imm_q[0];
            end
            IMM_J: begin
                enc_instr[31]    = s1_imm_q[20];
                enc_instr[19:12] = s1_imm_q[19:12];
                enc_instr[20]    = s1_imm_q[11];
                enc_instr[30:21] = s1_imm_q[10:1];
                enc_err = ~((&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20])) | s1_imm_q[0];
            end
            IMM_U: begin
                enc_instr[31:12] = s1_imm_q[31:12];
                enc_err = |s1_imm_q[11:0];
            end
            default: begin
                enc_instr = s1_base_q;
                enc_err   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_type_q   <= 3'b000;
            s1_imm_q    <= 32'h0;
            s1_base_q   <= 32'h0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= 32'h0;
            s2_err_q    <= 1'b0;
            addr_q      <= BASE_ADDR;
            err_count_q <= 8'h00;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            addr_q      <= addr_d;
            err_count_q <= err_count_d;
            if (in_accept) begin
                s1_type_q <= imm_type;
                s1_imm_q  <= imm_val;
                s1_base_q <= base_instr;
            end
            if (s1_adv) begin
                s2_instr_q <= enc_instr;
                s2_err_q   <= enc_err;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign instr_out = s2_instr_q;
    assign range_err = s2_err_q;
    assign out_addr  = addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: a bit-level reference model feeds a queue
// that a negedge monitor drains on every output transfer.
module tb_imm_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_type;
    logic [31:0] imm_val;
    logic [31:0] base_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        range_err;
    logic [31:0] out_addr;
    logic [7:0]  err_count;

    imm_encoder #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_type  (imm_type),
        .imm_val   (imm_val),
        .base_instr(base_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_out (instr_out),
        .range_err (range_err),
        .out_addr  (out_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] model_addr = BASE;
    logic [7:0]  model_cnt = 8'h00;
    logic        rand_ready = 1'b0;

    // Reference encoder written bit-by-bit with arithmetic range checks.
    task automatic model(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                         output logic [31:0] r, output logic e);
        int signed s;
        s = $signed(imm);
        r = base;
        e = 1'b0;
        case (t)
            3'd0: begin
                for (int i = 0; i < 12; i++) r[20+i] = imm[i];
                e = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                for (int i = 0; i < 7; i++) r[25+i] = imm[5+i];
                for (int i = 0; i < 5; i++) r[7+i] = imm[i];
                e = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                r[31] = imm[12];
                r[7]  = imm[11];
                for (int i = 0; i < 6; i++) r[25+i] = imm[5+i];
                for (int i = 0; i < 4; i++) r[8+i] = imm[1+i];
                e = (s < -4096) || (s > 4095) || (s % 2 != 0);
            end
            3'd3: begin
                r[31] = imm[20];
                r[20] = imm[11];
                for (int i = 0; i < 8; i++) r[12+i] = imm[12+i];
                for (int i = 0; i < 10; i++) r[21+i] = imm[1+i];
                e = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            end
            3'd4: begin
                for (int i = 12; i < 32; i++) r[i] = imm[i];
                e = (imm % 4096) != 0;
            end
            default: e = 1'b1;
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t x;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got instr %h with empty queue", instr_out);
            end else begin
                x = sb.pop_front();
                if (instr_out !== x.instr || range_err !== x.err || out_addr !== model_addr
                    || err_count !== model_cnt) begin
                    tests_failed++;
                    $display("FAIL sb_beat: got instr %h err %b addr %h cnt %h, want %h %b %h %h",
                             instr_out, range_err, out_addr, err_count,
                             x.instr, x.err, model_addr, model_cnt);
                end
                model_addr = model_addr + 32'd4;
                if (x.err && model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Call at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
        logic [31:0] ei;
        logic        ee;
        int          guard;
        model(t, imm, base, ei, ee);
        imm_type   = t;
        imm_val    = imm;
        base_instr = base;
        in_valid   = 1'b1;
        guard      = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready %b, want 1", in_ready);
        end else begin
            sb.push_back('{ei, ee});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        out_ready = 1'b1;
        guard = 0;
        while ((sb.size() != 0 || out_valid) && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout: %0d beats left, want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_addr = BASE;
        model_cnt  = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        imm_type = 3'd0;
        imm_val = 32'h0;
        base_instr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_addr !== BASE || err_count !== 8'h00
            || instr_out !== 32'h0 || range_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: valid %b rdy %b addr %h cnt %h instr %h err %b, want 0 1 %h 00 0 0",
                     out_valid, in_ready, out_addr, err_count, instr_out, range_err, BASE);
        end
    endtask

    task automatic test_latency();
        logic [31:0] ei;
        logic        ee;
        do_reset();
        out_ready = 1'b1;
        model(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, ei, ee);
        sb.push_back('{ei, ee});
        imm_type = 3'd0;
        imm_val = 32'hFFFF_FFFF;
        base_instr = 32'h0000_0013;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early: out_valid %b one cycle after accept, want 0", out_valid);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || instr_out !== 32'hFFF0_0013 || range_err !== 1'b0 || out_addr !== BASE) begin
            tests_failed++;
            $display("FAIL itype_direct: valid %b instr %h err %b addr %h, want 1 fff00013 0 %h",
                     out_valid, instr_out, range_err, out_addr, BASE);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_types();
        logic [2:0]  tt[6] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd5, 3'd0};
        logic [31:0] ti[6] = '{32'hFFFF_FFFE, 32'h0000_0003, 32'h1234_5000, 32'hFFFF_F800, 32'h0000_0001, 32'h0000_0800};
        logic [31:0] tb[6] = '{32'h0000_0063, 32'h0000_006F, 32'h0000_0037, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0013};
        logic [31:0] xi[6] = '{32'hFE00_0FE3, 32'h0020_006F, 32'h1234_5037, 32'h81FF_F07F, 32'hDEAD_BEEF, 32'h8000_0013};
        logic        xe[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0]  xc[6] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int guard;
            send(tt[k], ti[k], tb[k]);
            guard = 0;
            @(negedge clk);
            while (!out_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            tests_run++;
            if (out_valid !== 1'b1 || instr_out !== xi[k] || range_err !== xe[k]) begin
                tests_failed++;
                $display("FAIL type_direct_%0d: valid %b instr %h err %b, want 1 %h %b",
                         k, out_valid, instr_out, range_err, xi[k], xe[k]);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (err_count !== xc[k]) begin
                tests_failed++;
                $display("FAIL err_count_%0d: got %h, want %h", k, err_count, xc[k]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        do_reset();
        out_ready = 1'b0;
        send(3'd0, 32'h0000_0005, 32'h0000_0093);
        send(3'd4, 32'hABCD_E000, 32'h0000_00B7);
        held = sb[0].instr;
        imm_type = 3'd1;
        imm_val = 32'h0000_0010;
        base_instr = 32'h0000_0023;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr_out !== held || out_addr !== BASE) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: rdy %b valid %b instr %h addr %h, want 0 1 %h %h",
                         k, in_ready, out_valid, instr_out, out_addr, held, BASE);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'd1, 32'h0000_0010, 32'h0000_0023);
        drain();
        tests_run++;
        if (out_addr !== BASE + 32'd12) begin
            tests_failed++;
            $display("FAIL stall_addr: got %h, want %h", out_addr, BASE + 32'd12);
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            logic [31:0] imm;
            imm = (k % 3 == 0) ? $urandom : 32'($signed(12'($urandom)));
            if (k % 5 == 0) imm = imm & 32'hFFFF_F000;
            send(3'($urandom_range(0, 7)), imm, $urandom);
        end
        @(posedge clk);
        rand_ready = 1'b0;
        #1;
        drain();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(3'd6, 32'h0, 32'h1234_5678);
        drain();
        tests_run++;
        if (err_count !== 8'd5) begin
            tests_failed++;
            $display("FAIL pre_reset_count: got %h, want 05", err_count);
        end
        out_ready = 1'b0;
        send(3'd0, 32'h0000_0001, 32'h0000_0013);
        send(3'd0, 32'h0000_0002, 32'h0000_0013);
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        model_addr = BASE;
        model_cnt = 8'h00;
        tests_run++;
        if (out_valid !== 1'b0 || err_count !== 8'h00 || out_addr !== BASE || in_ready !== 1'b1
            || instr_out !== 32'h0 || range_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midflight_reset: valid %b cnt %h addr %h rdy %b instr %h err %b, want 0 00 %h 1 0 0",
                     out_valid, err_count, out_addr, in_ready, instr_out, range_err, BASE);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stale_beat_%0d: out_valid %b, want 0", k, out_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 262; k++) send(3'd7, 32'($urandom), 32'($urandom));
        drain();
        tests_run++;
        if (err_count !== 8'hFF) begin
            tests_failed++;
            $display("FAIL err_saturate: got %h, want ff", err_count);
        end
        send(3'd3, 32'h0000_0001, 32'h0000_006F);
        drain();
        tests_run++;
        if (err_count !== 8'hFF) begin
            tests_failed++;
            $display("FAIL err_hold: got %h, want ff", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_types();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
